// File: rtl/lsu_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mmio : multi-cycle load/store unit, data RAM + memory-mapped IO port     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module lsu_mmio #(
  parameter int RAM_WORDS   = 16384,
  parameter int IO_BIT      = 22,
  parameter int IO_WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [31:0] io_rdata,
  input  logic        io_ack
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int WW = $clog2(IO_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(IO_WAIT_MAX - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RAM = 2'd1, S_IO = 2'd2, S_RESP = 2'd3} state_t;

  state_t        state_q;
  logic [AW+1:0] addr_q;
  logic [2:0]    f3_q;
  logic          store_q;
  logic [31:0]   wdata_q;
  logic [WW-1:0] wait_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_data_q;
  logic          io_rd_q;
  logic          io_wr_q;
  logic [31:0]   io_addr_q;
  logic [31:0]   io_wdata_q;
  logic [31:0]   ram_rdata_q;
  logic [31:0]   mem_q [RAM_WORDS];

  logic          accept;
  logic          misalign;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;

  // funct3[1] set means word-sized (size code 11 is treated as a word)
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = a[0] ? h[15:8] : h[7:0];
    if (f3[1])
      return w;
    else if (f3[0])
      return f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
    else
      return f3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
  endfunction

  assign accept   = req_valid && (state_q == S_IDLE);
  assign misalign = (req_funct3[1] && (req_addr[1:0] != 2'b00)) ||
                    (!req_funct3[1] && req_funct3[0] && req_addr[0]);

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    if (f3_q[1]) begin
      be        = 4'b1111;
      wdata_rep = wdata_q;
    end else if (f3_q[0]) begin
      be        = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_q[15:0]}};
    end else begin
      be        = 4'b0001 << addr_q[1:0];
      wdata_rep = {4{wdata_q[7:0]}};
    end
  end

  // Read is issued at accept so the word is ready while in S_RAM
  always_ff @(posedge clk) begin
    if (state_q == S_RAM && store_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    if (accept) ram_rdata_q <= mem_q[req_addr[AW+1:2]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      f3_q        <= '0;
      store_q     <= 1'b0;
      wdata_q     <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      io_rd_q     <= 1'b0;
      io_wr_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[AW+1:0];
            f3_q    <= req_funct3;
            store_q <= req_store;
            wdata_q <= req_wdata;
            if (misalign) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else if (req_addr[IO_BIT]) begin
              state_q    <= S_IO;
              io_rd_q    <= !req_store;
              io_wr_q    <= req_store;
              io_addr_q  <= req_addr;
              io_wdata_q <= req_wdata;
              wait_q     <= '0;
            end else begin
              state_q <= S_RAM;
            end
          end
        end
        S_RAM: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= store_q ? 32'h0 : load_ext(ram_rdata_q, addr_q[1:0], f3_q);
        end
        S_IO: begin
          // An ack on the final wait cycle still completes without error
          if (io_ack) begin
            state_q     <= S_RESP;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= store_q ? 32'h0 : load_ext(io_rdata, addr_q[1:0], f3_q);
          end else if (wait_q == WAIT_LAST) begin
            state_q     <= S_RESP;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;

endmodule
`default_nettype wire
